// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//   Shares one 32-bit shifter datapath (SLL / SRL / SRA / pass-through) between
//   two requesters. A round-robin arbiter picks one requester per cycle, and
//   its result is captured in a single registered output stage.
//
//   The three shifter blocks are included in this file so that it is
//   self-contained:
//     shift_left_logical      zero-filling left shift
//     shift_right_logical     zero-filling right shift
//     shift_right_arithmetic  sign-filling right shift
//   Each one is a log2(N)-stage barrel shifter.
//
// Ports (shift_arbiter)
//   clk          in   1    clock; all state updates happen on posedge
//   rst          in   1    synchronous, active-high reset
//   req0_valid   in   1    requester 0 offers an operation
//   req0_ready   out  1    requester 0 is accepted this cycle
//   req0_in      in   N    operand for requester 0
//   req0_shamt   in   SHW  shift amount for requester 0
//   req0_op      in   2    00=SLL 01=SRL 10=SRA 11=pass-through
//   req1_*                 same five signals for requester 1
//   res_valid    out  1    the result register holds a valid result
//   res_ready    in   1    the consumer takes the result this cycle
//   res_out      out  N    shifted result
//   res_id       out  1    requester that produced res_out
//   state_dbg    out  1    output-stage FSM state (0=EMPTY, 1=FULL)
//
// Handshake semantics (all three ports): a transfer happens on a posedge
// where valid && ready are both high. A producer holds valid and its payload
// stable until that transfer. Ready may depend combinationally on valid, but
// valid never depends on ready. While rst=1 no transfer takes place.
// -----------------------------------------------------------------------------

module shift_left_logical #(
   parameter int N   = 32,
   parameter int SHW = 5
) (
   input  logic [N-1:0]   din,
   input  logic [SHW-1:0] shamt,
   output logic [N-1:0]   dout
);
   logic [N-1:0] stage [0:SHW];

   assign stage[0] = din;

   for (genvar s = 0; s < SHW; s++) begin : g_stage
      localparam int SH = 1 << s;
      assign stage[s+1] = shamt[s] ? {stage[s][N-1-SH:0], {SH{1'b0}}}
                                   : stage[s];
   end

   assign dout = stage[SHW];
endmodule

module shift_right_logical #(
   parameter int N   = 32,
   parameter int SHW = 5
) (
   input  logic [N-1:0]   din,
   input  logic [SHW-1:0] shamt,
   output logic [N-1:0]   dout
);
   logic [N-1:0] stage [0:SHW];

   assign stage[0] = din;

   for (genvar s = 0; s < SHW; s++) begin : g_stage
      localparam int SH = 1 << s;
      assign stage[s+1] = shamt[s] ? {{SH{1'b0}}, stage[s][N-1:SH]}
                                   : stage[s];
   end

   assign dout = stage[SHW];
endmodule

module shift_right_arithmetic #(
   parameter int N   = 32,
   parameter int SHW = 5
) (
   input  logic [N-1:0]   din,
   input  logic [SHW-1:0] shamt,
   output logic [N-1:0]   dout
);
   logic [N-1:0] stage [0:SHW];
   logic         fill;

   // The sign bit never changes through the stages, so every stage fills
   // with the original operand's MSB. The fill is built explicitly rather
   // than with >>> to avoid any signedness surprises in mixed expressions.
   assign fill     = din[N-1];
   assign stage[0] = din;

   for (genvar s = 0; s < SHW; s++) begin : g_stage
      localparam int SH = 1 << s;
      assign stage[s+1] = shamt[s] ? {{SH{fill}}, stage[s][N-1:SH]}
                                   : stage[s];
   end

   assign dout = stage[SHW];
endmodule

module shift_arbiter #(
   parameter int N   = 32,
   parameter int SHW = 5
) (
   input  logic           clk,
   input  logic           rst,

   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [N-1:0]   req0_in,
   input  logic [SHW-1:0] req0_shamt,
   input  logic [1:0]     req0_op,

   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [N-1:0]   req1_in,
   input  logic [SHW-1:0] req1_shamt,
   input  logic [1:0]     req1_op,

   output logic           res_valid,
   input  logic           res_ready,
   output logic [N-1:0]   res_out,
   output logic           res_id,

   output logic           state_dbg
);
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_SRA  = 2'b10;

   out_state_t     state;
   out_state_t     state_nxt;
   logic           last_grant;
   logic [N-1:0]   res_out_q;
   logic           res_id_q;

   logic           can_accept;
   logic           grant0;
   logic           grant1;
   logic           acc0;
   logic           acc1;
   logic           accept;

   logic [N-1:0]   sel_in;
   logic [SHW-1:0] sel_shamt;
   logic [1:0]     sel_op;
   logic [N-1:0]   sll_out;
   logic [N-1:0]   srl_out;
   logic [N-1:0]   sra_out;
   logic [N-1:0]   shift_res;

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   // The output register can take a new result when it is empty, or when
   // the consumer is draining it in this same cycle.
   assign can_accept = (state == EMPTY) || res_ready;

   // A lone valid requester wins. On a tie, the requester that did not win
   // the last accept is chosen. last_grant resets to 1, so requester 0
   // wins the first tie.
   assign grant0 = req0_valid && (!req1_valid || last_grant);
   assign grant1 = req1_valid && (!req0_valid || !last_grant);

   assign req0_ready = grant0 && can_accept && !rst;
   assign req1_ready = grant1 && can_accept && !rst;

   assign acc0   = req0_valid && req0_ready;
   assign acc1   = req1_valid && req1_ready;
   assign accept = acc0 || acc1;

   // ---------------------------------------------------------------------
   // Shared datapath: mux the granted operand, shift three ways, pick by op
   // ---------------------------------------------------------------------
   assign sel_in    = grant1 ? req1_in    : req0_in;
   assign sel_shamt = grant1 ? req1_shamt : req0_shamt;
   assign sel_op    = grant1 ? req1_op    : req0_op;

   shift_left_logical #(.N(N), .SHW(SHW)) u_sll (
      .din   (sel_in),
      .shamt (sel_shamt),
      .dout  (sll_out)
   );

   shift_right_logical #(.N(N), .SHW(SHW)) u_srl (
      .din   (sel_in),
      .shamt (sel_shamt),
      .dout  (srl_out)
   );

   shift_right_arithmetic #(.N(N), .SHW(SHW)) u_sra (
      .din   (sel_in),
      .shamt (sel_shamt),
      .dout  (sra_out)
   );

   always_comb begin
      shift_res = sel_in;
      case (sel_op)
         OP_SLL:  shift_res = sll_out;
         OP_SRL:  shift_res = srl_out;
         OP_SRA:  shift_res = sra_out;
         default: shift_res = sel_in;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output-stage FSM
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (accept) state_nxt = FULL;
         FULL:  if (res_ready && !accept) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         res_out_q  <= '0;
         res_id_q   <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state <= state_nxt;
         // Priority rotates only on an accept; a stalled output leaves it
         // alone, so the waiting loser still wins next.
         if (accept) begin
            res_out_q  <= shift_res;
            res_id_q   <= acc1;
            last_grant <= acc1;
         end
      end
   end

   assign res_valid = (state == FULL);
   assign res_out   = res_out_q;
   assign res_id    = res_id_q;
   assign state_dbg = state;
endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//   Directed testbench for shift_arbiter. It drives one linear sequence of
//   steps, and every expected value in it is a hand-computed constant.
// -----------------------------------------------------------------------------

module tb_shift_arbiter;
   localparam int N   = 32;
   localparam int SHW = 5;

   logic           clk;
   logic           rst;
   logic           req0_valid;
   logic           req0_ready;
   logic [N-1:0]   req0_in;
   logic [SHW-1:0] req0_shamt;
   logic [1:0]     req0_op;
   logic           req1_valid;
   logic           req1_ready;
   logic [N-1:0]   req1_in;
   logic [SHW-1:0] req1_shamt;
   logic [1:0]     req1_op;
   logic           res_valid;
   logic           res_ready;
   logic [N-1:0]   res_out;
   logic           res_id;
   logic           state_dbg;

   int n_vec;
   int n_err;

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   shift_arbiter #(.N(N), .SHW(SHW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_in    (req0_in),
      .req0_shamt (req0_shamt),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_in    (req1_in),
      .req1_shamt (req1_shamt),
      .req1_op    (req1_op),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_out    (res_out),
      .res_id     (res_id),
      .state_dbg  (state_dbg)
   );

   // ---------------- driver tasks ----------------
   // Advance past the next rising edge; inputs are then changed and outputs
   // sampled well away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive0(input logic v, input logic [N-1:0] d,
                         input logic [SHW-1:0] sh, input logic [1:0] op);
      req0_valid = v;
      req0_in    = d;
      req0_shamt = sh;
      req0_op    = op;
   endtask

   task automatic drive1(input logic v, input logic [N-1:0] d,
                         input logic [SHW-1:0] sh, input logic [1:0] op);
      req1_valid = v;
      req1_in    = d;
      req1_shamt = sh;
      req1_op    = op;
   endtask

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [N-1:0] obs,
                      input logic [N-1:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic v,
                          input logic [N-1:0] d, input logic id);
      chk({tag, ".valid"}, {31'd0, res_valid}, {31'd0, v});
      chk({tag, ".out"},   res_out,            d);
      chk({tag, ".id"},    {31'd0, res_id},    {31'd0, id});
   endtask

   task automatic chk_rdy(input string tag, input logic r0, input logic r1);
      chk({tag, ".ready0"}, {31'd0, req0_ready}, {31'd0, r0});
      chk({tag, ".ready1"}, {31'd0, req1_ready}, {31'd0, r1});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst       = 1'b1;
      res_ready = 1'b0;
      drive0(1'b1, 32'h8000_0000, 5'd31, 2'b01);  // SRL -> 0x00000001
      drive1(1'b1, 32'h0000_0001, 5'd4,  2'b00);  // SLL -> 0x00000010

      // Reset held two cycles with both requesters valid.
      tick();
      chk_res("rst1", 1'b0, 32'h0, 1'b0);
      chk_rdy("rst1", 1'b0, 1'b0);
      tick();
      chk_res("rst2", 1'b0, 32'h0, 1'b0);
      chk_rdy("rst2", 1'b0, 1'b0);
      chk("rst2.state", {31'd0, state_dbg}, 32'd0);

      // Release: req0 wins the first tie.
      rst       = 1'b0;
      res_ready = 1'b1;
      settle();
      chk_rdy("release", 1'b1, 1'b0);

      // Edge: accept req0 SRL.
      tick();
      chk_res("srl31", 1'b1, 32'h0000_0001, 1'b0);
      chk("srl31.state", {31'd0, state_dbg}, 32'd1);
      drive0(1'b1, 32'h8000_0000, 5'd31, 2'b10);  // SRA -> 0xFFFFFFFF
      settle();
      chk_rdy("rr1", 1'b0, 1'b1);

      // Edge: accept req1 SLL (it lost the tie and held its request).
      tick();
      chk_res("sll4", 1'b1, 32'h0000_0010, 1'b1);
      drive1(1'b1, 32'hDEAD_BEEF, 5'd7, 2'b11);   // pass-through
      settle();
      chk_rdy("rr2", 1'b1, 1'b0);

      tick();
      chk_res("sra31", 1'b1, 32'hFFFF_FFFF, 1'b0);
      drive0(1'b1, 32'h1234_5678, 5'd0, 2'b01);   // SRL by 0 -> unchanged
      settle();
      chk_rdy("rr3", 1'b0, 1'b1);

      tick();
      chk_res("pass", 1'b1, 32'hDEAD_BEEF, 1'b1);

      tick();
      chk_res("srl0", 1'b1, 32'h1234_5678, 1'b0);

      // Backpressure: output FULL, consumer stalls.
      res_ready = 1'b0;
      drive0(1'b1, 32'hFFFF_FFFF, 5'd31, 2'b00);  // SLL -> 0x80000000
      drive1(1'b1, 32'h8000_0000, 5'd4,  2'b10);  // SRA -> 0xF8000000
      settle();
      chk_rdy("bp0", 1'b0, 1'b0);
      tick();
      chk_res("bp1", 1'b1, 32'h1234_5678, 1'b0);
      chk_rdy("bp1", 1'b0, 1'b0);
      tick();
      chk_res("bp2", 1'b1, 32'h1234_5678, 1'b0);
      chk_rdy("bp2", 1'b0, 1'b0);

      // Consumer resumes: priority did not rotate, so req1 goes next, and
      // the drain and refill happen on the same edge.
      res_ready = 1'b1;
      settle();
      chk_rdy("bp_release", 1'b0, 1'b1);
      tick();
      chk_res("bp_refill", 1'b1, 32'hF800_0000, 1'b1);
      drive1(1'b1, 32'hFFFF_FFFF, 5'd31, 2'b01);  // SRL -> 0x00000001
      settle();
      chk_rdy("after_bp", 1'b1, 1'b0);

      tick();
      chk_res("sll31", 1'b1, 32'h8000_0000, 1'b0);

      // Reset while FULL with req1 waiting.
      res_ready = 1'b0;
      settle();
      chk_rdy("waiting", 1'b0, 1'b0);
      rst = 1'b1;
      settle();
      chk_rdy("rst_full", 1'b0, 1'b0);
      tick();
      chk_res("rst_full", 1'b0, 32'h0, 1'b0);

      rst       = 1'b0;
      res_ready = 1'b1;
      settle();
      chk_rdy("rst_tie", 1'b1, 1'b0);
      tick();
      chk_res("rst_tie", 1'b1, 32'h8000_0000, 1'b0);
      drive0(1'b0, 32'h0, 5'd0, 2'b00);
      tick();
      chk_res("rst_next", 1'b1, 32'h0000_0001, 1'b1);

      // Lone requester 1 right after winning: still granted.
      drive1(1'b1, 32'hA5A5_A5A5, 5'd9, 2'b11);
      settle();
      chk_rdy("lone1", 1'b0, 1'b1);
      tick();
      chk_res("lone1", 1'b1, 32'hA5A5_A5A5, 1'b1);

      // Drain with nothing offered: back to EMPTY.
      drive1(1'b0, 32'h0, 5'd0, 2'b00);
      tick();
      chk("drain.valid", {31'd0, res_valid}, 32'd0);
      chk("drain.state", {31'd0, state_dbg}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
